// File: rtl/core_pkg.sv
// Shared core types: PC/instruction widths, fetch-queue entry layout and depth default.
// Pure declarations; no timing.
// No flow control lives here.
package core_pkg;
    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 8;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [XLEN-1:0] instr_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fq_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction
endpackage

// File: rtl/fetch_queue_stats.sv
// Saturating cycle counters for queue-full stalls and empty cycles.
// Counts land one edge after the qualifying cycle.
// No backpressure; cleared only by rst.
module fetch_queue_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        full_evt,
    input  logic        empty_evt,
    output logic [31:0] stat_full_cycles,
    output logic [31:0] stat_empty_cycles
);
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_full_cycles  <= '0;
            stat_empty_cycles <= '0;
        end else begin
            if (full_evt && (stat_full_cycles != '1))
                stat_full_cycles <= stat_full_cycles + 32'd1;
            if (empty_evt && (stat_empty_cycles != '1))
                stat_empty_cycles <= stat_empty_cycles + 32'd1;
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// 2-wide compacting instruction queue between fetch and dual-issue decode; stats under FETCH_QUEUE_STATS_EN.
// Enqueued entries visible one edge later, no bypass; deq outputs combinational from head.
// enq_ready needs two free slots from registered count only; decode pops 0..2 per cycle.
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = core_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [1:0]               enq_mask,
    input  logic [XLEN-1:0]          enq_pc,
    input  logic [XLEN-1:0]          enq_instr0,
    input  logic [XLEN-1:0]          enq_instr1,
    output logic                     enq_ready,
    output logic [1:0]               deq_valid,
    output logic [XLEN-1:0]          deq_pc0,
    output logic [XLEN-1:0]          deq_pc1,
    output logic [XLEN-1:0]          deq_instr0,
    output logic [XLEN-1:0]          deq_instr1,
    input  logic [1:0]               deq_count,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              stat_full_cycles,
    output logic [31:0]              stat_empty_cycles
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head, tail, head1, tail1;
    logic [CW-1:0] count;
    fq_entry_t     mem [DEPTH];

    logic          enq_fire;
    logic [1:0]    enq_num, deq_req, deq_avail, deq_num;
    fq_entry_t     wr0, wr1;

    assign enq_ready = (count <= CW'(DEPTH - 2));
    assign enq_fire  = enq_valid && enq_ready && !flush && !rst;
    assign enq_num   = enq_fire ? popcount2(enq_mask) : 2'd0;

    // Over-requests are clamped to what is actually present.
    assign deq_req   = (deq_count == 2'd3) ? 2'd2 : deq_count;
    assign deq_avail = (count >= CW'(2)) ? 2'd2 : count[1:0];
    assign deq_num   = flush ? 2'd0 : ((deq_req > deq_avail) ? deq_avail : deq_req);

    assign head1 = head + AW'(1);
    assign tail1 = tail + AW'(1);

    // Slot 0 of the write pair takes the lowest valid lane, which compacts mask 10.
    assign wr0 = enq_mask[0] ? '{pc: enq_pc, instr: enq_instr0}
                             : '{pc: enq_pc + XLEN'(4), instr: enq_instr1};
    assign wr1 = '{pc: enq_pc + XLEN'(4), instr: enq_instr1};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deq_num);
            tail  <= tail + AW'(enq_num);
            count <= count + CW'(enq_num) - CW'(deq_num);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_num != 2'd0)
            mem[tail] <= wr0;
        if (enq_num == 2'd2)
            mem[tail1] <= wr1;
    end

    assign deq_valid = {count >= CW'(2), count != '0};
    assign occupancy = count;

    always_comb begin
        deq_pc0    = '0;
        deq_instr0 = '0;
        deq_pc1    = '0;
        deq_instr1 = '0;
        if (deq_valid[0]) begin
            deq_pc0    = mem[head].pc;
            deq_instr0 = mem[head].instr;
        end
        if (deq_valid[1]) begin
            deq_pc1    = mem[head1].pc;
            deq_instr1 = mem[head1].instr;
        end
    end

    // Decode must never pop more entries than it was shown.
    assert property (@(posedge clk) disable iff (rst || flush)
                     (deq_count <= 2'd2) && (deq_count <= deq_avail));

`ifdef FETCH_QUEUE_STATS_EN
    fetch_queue_stats u_stats (
        .clk               (clk),
        .rst               (rst),
        .full_evt          (enq_valid && !enq_ready),
        .empty_evt         (count == '0),
        .stat_full_cycles  (stat_full_cycles),
        .stat_empty_cycles (stat_empty_cycles)
    );
`else
    assign stat_full_cycles  = '0;
    assign stat_empty_cycles = '0;
`endif
endmodule
